// File: rtl/fir_stream_ctrl.sv
// Stream sequencer for the 17-tap FIR: primes the delay line, watches for input gaps
// and decimates the filtered stream into a registered output with a valid strobe.
module fir_stream_ctrl #(
    parameter int WIDTH   = 16,
    parameter int TAPS    = 17,
    parameter int FIR_LAT = 3,
    parameter int DECIM_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic [DECIM_W-1:0]        decim_i,
    input  logic                      in_valid_i,
    input  logic signed [WIDTH-1:0]   in_data_i,
    input  logic                      err_clr_i,
    output logic signed [WIDTH-1:0]   fir_data_o,
    output logic                      fir_start_o,
    input  logic signed [WIDTH-1:0]   fir_data_i,
    output logic                      out_valid_o,
    output logic signed [WIDTH-1:0]   out_data_o,
    output logic                      busy_o,
    output logic                      gap_err_o,
    output logic [1:0]                state_o
);

    localparam int PCNT_W = $clog2(TAPS + FIR_LAT);
    // Last prime count before the FIR result covers only valid samples.
    localparam logic [PCNT_W-1:0] PRIME_LAST = PCNT_W'(TAPS - 2 + FIR_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [PCNT_W-1:0]   prime_cnt, prime_cnt_nxt;
    logic [DECIM_W-1:0]  dec_cnt, dec_cnt_nxt;
    logic [DECIM_W-1:0]  decim_q, decim_nxt;
    logic                capture;
    logic                gap_set;
    logic                gap_err;
    logic                vld_p1;
    logic signed [WIDTH-1:0] data_p1;

    assign fir_start_o = (state != IDLE);
    assign fir_data_o  = (state != IDLE && in_valid_i) ? in_data_i : '0;
    assign busy_o      = (state != IDLE);
    assign state_o     = state;
    assign gap_err_o   = gap_err;
    assign out_valid_o = vld_p1;
    assign out_data_o  = data_p1;

    always_comb begin
        state_nxt     = state;
        prime_cnt_nxt = prime_cnt;
        dec_cnt_nxt   = dec_cnt;
        decim_nxt     = decim_q;
        capture       = 1'b0;
        gap_set       = 1'b0;
        case (state)
            IDLE: begin
                if (en_i) begin
                    state_nxt     = PRIME;
                    prime_cnt_nxt = '0;
                    decim_nxt     = (decim_i == '0) ? DECIM_W'(1) : decim_i;
                end
            end
            PRIME: begin
                if (!en_i) begin
                    state_nxt = IDLE;
                end else if (!in_valid_i) begin
                    prime_cnt_nxt = '0;
                end else if (prime_cnt == PRIME_LAST) begin
                    state_nxt   = RUN;
                    dec_cnt_nxt = '0;
                end else begin
                    prime_cnt_nxt = prime_cnt + PCNT_W'(1);
                end
            end
            RUN: begin
                // The current result is clean even when this cycle's input is missing.
                capture     = (dec_cnt == '0);
                dec_cnt_nxt = (dec_cnt == decim_q - DECIM_W'(1)) ? '0 : dec_cnt + DECIM_W'(1);
                gap_set     = !in_valid_i;
                if (!en_i) begin
                    state_nxt = IDLE;
                end else if (!in_valid_i) begin
                    state_nxt     = PRIME;
                    prime_cnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prime_cnt <= '0;
            dec_cnt   <= '0;
            decim_q   <= '0;
            gap_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            prime_cnt <= prime_cnt_nxt;
            dec_cnt   <= dec_cnt_nxt;
            decim_q   <= decim_nxt;
            if (gap_set)
                gap_err <= 1'b1;
            else if (err_clr_i)
                gap_err <= 1'b0;
        end
    end

    // Output stage: capture of the FIR result presented one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= capture;
            if (capture)
                data_p1 <= fir_data_i;
        end
    end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: a behavioural 17-tap FIR closes the loop, and a scoreboard
// checks every output strobe against hand-computed cycle/data expectations.
module tb_fir_stream_ctrl;

    localparam int WIDTH   = 16;
    localparam int DECIM_W = 8;
    localparam int NTAP    = 17;
    localparam longint COEF = 3855;  // 17 * 3855 = 65535

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     en_i = 1'b0;
    logic [DECIM_W-1:0]       decim_i = '0;
    logic                     in_valid_i = 1'b1;
    logic signed [WIDTH-1:0]  in_data_i = '0;
    logic                     err_clr_i = 1'b0;
    logic signed [WIDTH-1:0]  fir_data_o;
    logic                     fir_start_o;
    logic signed [WIDTH-1:0]  fir_data_i;
    logic                     out_valid_o;
    logic signed [WIDTH-1:0]  out_data_o;
    logic                     busy_o;
    logic                     gap_err_o;
    logic [1:0]               state_o;

    fir_stream_ctrl #(.WIDTH(WIDTH), .TAPS(17), .FIR_LAT(3), .DECIM_W(DECIM_W)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .decim_i(decim_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .err_clr_i(err_clr_i),
        .fir_data_o(fir_data_o), .fir_start_o(fir_start_o), .fir_data_i(fir_data_i),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .busy_o(busy_o),
        .gap_err_o(gap_err_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FIR: shifts only while started, 3-cycle result latency.
    logic signed [WIDTH-1:0] line [NTAP];
    logic signed [WIDTH-1:0] s1 = '0, s2 = '0, s3 = '0;
    initial for (int i = 0; i < NTAP; i++) line[i] = '0;
    assign fir_data_i = s3;

    always @(posedge clk) begin
        longint acc;
        if (fir_start_o) begin
            acc = longint'(fir_data_o) * COEF;
            for (int i = 0; i < NTAP - 1; i++) acc += longint'(line[i]) * COEF;
            for (int i = NTAP - 1; i > 0; i--) line[i] <= line[i-1];
            line[0] <= fir_data_o;
            s1 <= WIDTH'(acc >>> 16);
            s2 <= s1;
            s3 <= s2;
        end
    end

    int checks = 0;
    int errors = 0;
    int exp_cyc[$];
    int exp_dat[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int d);
        exp_cyc.push_back(c);
        exp_dat.push_back(d);
    endtask

    always @(negedge clk) begin
        int c, d;
        if (out_valid_o) begin
            if (exp_cyc.size() == 0) begin
                chk("unexpected_strobe_cycle", cyc, -1);
            end else begin
                c = exp_cyc.pop_front();
                d = exp_dat.pop_front();
                chk("strobe_cycle", cyc, c);
                chk("strobe_data", int'(out_data_o), d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        // Reset state with en low and a valid input present
        in_valid_i = 1'b1;
        in_data_i  = 16'sd1234;
        do_reset();
        tick();
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_out_data", int'(out_data_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_gap_err", int'(gap_err_o), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_fir_start", int'(fir_start_o), 0);
        chk("rst_fir_data", int'(fir_data_o), 0);

        // D=1, DC 1000
        in_data_i = 16'sd1000;
        decim_i = 8'd1;
        en_i = 1'b1;
        p = cyc + 1;
        for (int k = 20; k <= 40; k++) push(p + k, 999);
        run_until(p + 18);
        chk("d1_state_prime_end", int'(state_o), 1);
        tick();
        chk("d1_state_run", int'(state_o), 2);
        run_until(p + 39);
        en_i = 1'b0;
        run_until(p + 45);
        chk("d1_queue_empty", exp_cyc.size(), 0);

        // D=4, DC -1000
        do_reset();
        in_data_i = -16'sd1000;
        decim_i = 8'd4;
        en_i = 1'b1;
        p = cyc + 1;
        for (int k = 20; k <= 40; k += 4) push(p + k, -1000);
        run_until(p + 22);
        chk("d4_hold_data", int'(out_data_o), -1000);
        run_until(p + 41);
        en_i = 1'b0;
        run_until(p + 46);
        chk("d4_queue_empty", exp_cyc.size(), 0);

        // Gap in RUN, re-prime, error clear
        do_reset();
        in_data_i = 16'sd1000;
        decim_i = 8'd1;
        en_i = 1'b1;
        p = cyc + 1;
        for (int k = 20; k <= 31; k++) push(p + k, 999);
        for (int k = 51; k <= 56; k++) push(p + k, 999);
        run_until(p + 30);
        in_valid_i = 1'b0;
        #1;
        chk("gap_fir_data_zero", int'(fir_data_o), 0);
        chk("gap_err_before", int'(gap_err_o), 0);
        tick();
        in_valid_i = 1'b1;
        chk("gap_err_set", int'(gap_err_o), 1);
        chk("gap_state_prime", int'(state_o), 1);
        run_until(p + 50);
        chk("gap_err_sticky", int'(gap_err_o), 1);
        chk("gap_rerun_state", int'(state_o), 2);
        run_until(p + 52);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("gap_err_cleared", int'(gap_err_o), 0);
        run_until(p + 55);
        en_i = 1'b0;
        run_until(p + 60);
        chk("gap_queue_empty", exp_cyc.size(), 0);

        // Disable in RUN; decim change in RUN applies only after re-enable
        do_reset();
        decim_i = 8'd1;
        en_i = 1'b1;
        p = cyc + 1;
        for (int k = 20; k <= 26; k++) push(p + k, 999);
        run_until(p + 22);
        decim_i = 8'd3;
        run_until(p + 25);
        en_i = 1'b0;
        run_until(p + 28);
        chk("dis_state_idle", int'(state_o), 0);
        chk("dis_fir_start", int'(fir_start_o), 0);
        chk("dis_busy", int'(busy_o), 0);
        chk("dis_hold_data", int'(out_data_o), 999);
        chk("dis_queue_empty", exp_cyc.size(), 0);
        en_i = 1'b1;
        p = cyc + 1;
        push(p + 20, 999);
        push(p + 23, 999);
        push(p + 26, 999);
        run_until(p + 27);
        en_i = 1'b0;
        run_until(p + 32);
        chk("redec_queue_empty", exp_cyc.size(), 0);

        // Reset during PRIME, then full re-prime
        do_reset();
        decim_i = 8'd1;
        en_i = 1'b1;
        p = cyc + 1;
        run_until(p + 10);
        rst = 1'b1;
        tick();
        chk("rstmid_state", int'(state_o), 0);
        chk("rstmid_busy", int'(busy_o), 0);
        rst = 1'b0;
        p = cyc + 1;
        for (int k = 20; k <= 23; k++) push(p + k, 999);
        run_until(p + 18);
        chk("rstmid_still_prime", int'(state_o), 1);
        run_until(p + 22);
        en_i = 1'b0;
        run_until(p + 28);
        chk("rstmid_queue_empty", exp_cyc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
